// File: rtl/fc_flatten_writer.sv
// fc_flatten_writer
// Takes pooled feature-map pixels and writes them into the FC flatten input
// memory. The pixels arrive pixel-major with the channels interleaved. The FC
// stage reads them channel-major, so this block reorders them by generating the
// write address. After the last write has landed it raises the FC enable level.
// It then waits for the FC all_end signal and reports completion.
//
// Ports:
//   clk         in   clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   single-cycle frame request, honoured only when idle
//   pix_valid   in   upstream pixel valid
//   pix_data    in   upstream pixel value (16 bit)
//   pix_ready   out  pixel accepted this cycle when pix_valid is high
//   flat_we     out  flatten memory write enable
//   flat_value  out  flatten write data
//   flat_addr   out  flatten write address
//   fc_enable   out  FC start level / FC memory source select
//   fc_all_end  in   FC finished level
//   busy        out  high whenever not idle
//   done        out  one-cycle completion pulse
module fc_flatten_writer #(
    parameter int CH        = 2,
    parameter int MAP_H     = 7,
    parameter int MAP_W     = 1,
    parameter int ADDR_BASE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    output logic        pix_ready,
    output logic        flat_we,
    output logic [15:0] flat_value,
    output logic [15:0] flat_addr,
    output logic        fc_enable,
    input  logic        fc_all_end,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CH    > 1) ? $clog2(CH)    : 1;
    localparam int XW = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int YW = (MAP_H > 1) ? $clog2(MAP_H) : 1;

    localparam logic [CW-1:0] C_LAST  = CW'(CH - 1);
    localparam logic [XW-1:0] X_LAST  = XW'(MAP_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(MAP_H - 1);
    localparam logic [15:0]   BASE16  = 16'(ADDR_BASE);
    localparam logic [15:0]   PLANE16 = 16'(MAP_H * MAP_W);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_FLUSH = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]    state_r, state_nxt_s;
    logic [CW-1:0] c_r, c_nxt_s;
    logic [XW-1:0] x_r, x_nxt_s;
    logic [YW-1:0] y_r, y_nxt_s;
    // ch_base_r = ADDR_BASE + c*MAP_H*MAP_W and pos_r = y*MAP_W + x.
    // Both are kept incrementally, so the per-cycle path needs only adders.
    logic [15:0]   ch_base_r, ch_base_nxt_s;
    logic [15:0]   pos_r, pos_nxt_s;

    logic          pix_ready_r, flat_we_r, fc_enable_r, busy_r, done_r;
    logic [15:0]   flat_value_r, flat_addr_r;

    logic          xfer_s, last_s, frame_start_s;

    // pix_ready_r is high exactly in LOAD, so a handshake is a valid transfer.
    assign xfer_s        = pix_ready_r & pix_valid;
    assign last_s        = xfer_s & (c_r == C_LAST) & (x_r == X_LAST) & (y_r == Y_LAST);
    assign frame_start_s = (state_r == ST_IDLE) & start;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nxt_s = ST_LOAD;
                else       state_nxt_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (last_s) state_nxt_s = ST_FLUSH;
                else        state_nxt_s = ST_LOAD;
            end
            ST_FLUSH: state_nxt_s = ST_RUN;
            ST_RUN: begin
                if (fc_all_end) state_nxt_s = ST_DONE;
                else            state_nxt_s = ST_RUN;
            end
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter advance. c is innermost and carries into x, which carries into y.
    // pos steps by one whenever c wraps, whether x or y takes the carry.
    always_comb begin
        c_nxt_s       = c_r;
        x_nxt_s       = x_r;
        y_nxt_s       = y_r;
        ch_base_nxt_s = ch_base_r;
        pos_nxt_s     = pos_r;
        if (c_r == C_LAST) begin
            c_nxt_s       = '0;
            ch_base_nxt_s = BASE16;
            pos_nxt_s     = pos_r + 16'd1;
            if (x_r == X_LAST) begin
                x_nxt_s = '0;
                if (y_r == Y_LAST) y_nxt_s = '0;
                else               y_nxt_s = y_r + YW'(1);
            end else begin
                x_nxt_s = x_r + XW'(1);
            end
        end else begin
            c_nxt_s       = c_r + CW'(1);
            ch_base_nxt_s = ch_base_r + PLANE16;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // Counters: clear when a frame starts and advance on each transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_r       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            ch_base_r <= BASE16;
            pos_r     <= 16'd0;
        end else if (frame_start_s) begin
            c_r       <= '0;
            x_r       <= '0;
            y_r       <= '0;
            ch_base_r <= BASE16;
            pos_r     <= 16'd0;
        end else if (xfer_s) begin
            c_r       <= c_nxt_s;
            x_r       <= x_nxt_s;
            y_r       <= y_nxt_s;
            ch_base_r <= ch_base_nxt_s;
            pos_r     <= pos_nxt_s;
        end else begin
            c_r       <= c_r;
            x_r       <= x_r;
            y_r       <= y_r;
            ch_base_r <= ch_base_r;
            pos_r     <= pos_r;
        end
    end

    // Flatten write port: one registered write per transfer. Data and address hold otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flat_we_r    <= 1'b0;
            flat_value_r <= 16'h0000;
            flat_addr_r  <= 16'h0000;
        end else if (xfer_s) begin
            flat_we_r    <= 1'b1;
            flat_value_r <= pix_data;
            flat_addr_r  <= ch_base_r + pos_r;
        end else begin
            flat_we_r    <= 1'b0;
            flat_value_r <= flat_value_r;
            flat_addr_r  <= flat_addr_r;
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_ready_r <= 1'b0;
            fc_enable_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            pix_ready_r <= (state_nxt_s == ST_LOAD);
            fc_enable_r <= (state_nxt_s == ST_RUN);
            busy_r      <= (state_nxt_s != ST_IDLE);
            done_r      <= (state_nxt_s == ST_DONE);
        end
    end

    assign pix_ready  = pix_ready_r;
    assign flat_we    = flat_we_r;
    assign flat_value = flat_value_r;
    assign flat_addr  = flat_addr_r;
    assign fc_enable  = fc_enable_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_fc_flatten_writer.sv
// Testbench for fc_flatten_writer. It uses two instances. Instance A has the
// default geometry (2x7x1, base 0). Instance B has a 3x2x2 geometry at base 0x40.
// A select bit routes the stimulus to one instance and its outputs to the checks.
// Expected addresses come from the geometric flatten rule in exp_addr().
module tb_fc_flatten_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        fc_all_end;
    logic        sel;

    logic        a_ready, a_we, a_en, a_busy, a_done;
    logic [15:0] a_val, a_addr;
    logic        b_ready, b_we, b_en, b_busy, b_done;
    logic [15:0] b_val, b_addr;

    logic        o_ready, o_we, o_en, o_busy, o_done;
    logic [15:0] o_val, o_addr;

    int n_cmp = 0;
    int n_err = 0;
    int cfg_ch, cfg_h, cfg_w, cfg_base;

    always #5 clk = ~clk;

    fc_flatten_writer u_a (
        .clk(clk), .reset_n(reset_n), .start(start & ~sel),
        .pix_valid(pix_valid & ~sel), .pix_data(pix_data), .pix_ready(a_ready),
        .flat_we(a_we), .flat_value(a_val), .flat_addr(a_addr),
        .fc_enable(a_en), .fc_all_end(fc_all_end & ~sel),
        .busy(a_busy), .done(a_done)
    );

    fc_flatten_writer #(.CH(3), .MAP_H(2), .MAP_W(2), .ADDR_BASE(64)) u_b (
        .clk(clk), .reset_n(reset_n), .start(start & sel),
        .pix_valid(pix_valid & sel), .pix_data(pix_data), .pix_ready(b_ready),
        .flat_we(b_we), .flat_value(b_val), .flat_addr(b_addr),
        .fc_enable(b_en), .fc_all_end(fc_all_end & sel),
        .busy(b_busy), .done(b_done)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_we    = sel ? b_we    : a_we;
    assign o_val   = sel ? b_val   : a_val;
    assign o_addr  = sel ? b_addr  : a_addr;
    assign o_en    = sel ? b_en    : a_en;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_done  = sel ? b_done  : a_done;

    // Flatten address of the k-th pixel in arrival order, from the geometric rule.
    function automatic int exp_addr(input int k);
        int c, x, y;
        c = k % cfg_ch;
        x = (k / cfg_ch) % cfg_w;
        y = k / (cfg_ch * cfg_w);
        return (cfg_base + c * cfg_h * cfg_w + y * cfg_w + x) & 32'hFFFF;
    endfunction

    task automatic set_cfg(input logic s);
        sel = s;
        if (s) begin cfg_ch = 3; cfg_h = 2; cfg_w = 2; cfg_base = 64; end
        else   begin cfg_ch = 2; cfg_h = 7; cfg_w = 1; cfg_base = 0;  end
    endtask

    // Per-cycle invariants on both instances while out of reset.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            n_cmp++;
            if ((a_we & a_en) !== 1'b0 || (b_we & b_en) !== 1'b0) begin
                n_err++;
                $display("FAIL we_en_overlap: a=%b%b b=%b%b required no overlap", a_we, a_en, b_we, b_en);
            end
            n_cmp++;
            if ((a_ready & (a_en | a_done)) !== 1'b0 || (b_ready & (b_en | b_done)) !== 1'b0) begin
                n_err++;
                $display("FAIL ready_outside_load: a_ready=%b b_ready=%b required 0", a_ready, b_ready);
            end
        end
    end

    // mode 0: continuous, data 0x0100+k; 1: valid every other cycle; 2: random valid.
    // stop_at < frame length aborts after that many transfers.
    // inject adds one stall cycle with start and fc_all_end high during LOAD.
    task automatic do_frame(input int mode, input int stop_at, input bit inject);
        logic [15:0] dat [64];
        int  n, k, cyc;
        bit  v, injected, inj_now;
        n = cfg_ch * cfg_h * cfg_w;
        for (int i = 0; i < 64; i++)
            dat[i] = (mode == 0) ? 16'(16'h0100 + i) : 16'($urandom);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_cmp++;
        if (o_busy !== 1'b1 || o_ready !== 1'b1) begin
            n_err++;
            $display("FAIL start_latency: busy=%b ready=%b required 1 1", o_busy, o_ready);
        end
        k = 0; cyc = 0; injected = 1'b0;
        while (k < stop_at && cyc < 1000) begin
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (cyc % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            inj_now = 1'b0;
            if (inject && k == 3 && !injected) begin
                v = 1'b0; start = 1'b1; fc_all_end = 1'b1;
                injected = 1'b1; inj_now = 1'b1;
            end
            pix_valid = v;
            pix_data  = dat[k];
            @(negedge clk);
            start = 1'b0; fc_all_end = 1'b0; cyc++;
            n_cmp++;
            if (v) begin
                if (o_we !== 1'b1 || o_addr !== 16'(exp_addr(k)) || o_val !== dat[k]) begin
                    n_err++;
                    $display("FAIL write k=%0d: we=%b addr=%h val=%h required 1 %h %h",
                             k, o_we, o_addr, o_val, 16'(exp_addr(k)), dat[k]);
                end
                k++;
                n_cmp++;
                if (k < n && o_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL ready_in_load: ready=%b required 1", o_ready);
                end else if (k == n && (o_ready !== 1'b0 || o_en !== 1'b0)) begin
                    n_err++;
                    $display("FAIL flush_cycle: ready=%b en=%b required 0 0", o_ready, o_en);
                end
            end else begin
                if (o_we !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_write: we=%b required 0", o_we);
                end
                if (inj_now) begin
                    n_cmp++;
                    if (o_ready !== 1'b1 || o_en !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL ignore_in_load: ready=%b en=%b done=%b busy=%b required 1 0 0 1",
                                 o_ready, o_en, o_done, o_busy);
                    end
                end
            end
        end
        pix_valid = 1'b0;
        if (k < stop_at) begin
            n_cmp++; n_err++;
            $display("FAIL frame_timeout: transfers=%0d required %0d", k, stop_at);
        end
        if (stop_at == n) begin
            @(negedge clk);
            n_cmp++;
            if (o_en !== 1'b1 || o_we !== 1'b0 || o_ready !== 1'b0) begin
                n_err++;
                $display("FAIL enable_rise: en=%b we=%b ready=%b required 1 0 0", o_en, o_we, o_ready);
            end
        end
    endtask

    // Hold fc_all_end low for 'hold' RUN cycles with a stray start, then end the run.
    task automatic test_run_end(input int hold);
        for (int i = 0; i < hold; i++) begin
            fc_all_end = 1'b0;
            start = (i == 2);
            @(negedge clk);
            start = 1'b0;
            n_cmp++;
            if (o_en !== 1'b1 || o_done !== 1'b0 || o_we !== 1'b0 || o_busy !== 1'b1) begin
                n_err++;
                $display("FAIL run_hold i=%0d: en=%b done=%b we=%b busy=%b required 1 0 0 1",
                         i, o_en, o_done, o_we, o_busy);
            end
        end
        fc_all_end = 1'b1;
        @(negedge clk);
        fc_all_end = 1'b0;
        n_cmp++;
        if (o_en !== 1'b0 || o_done !== 1'b1 || o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL done_pulse: en=%b done=%b busy=%b required 0 1 1", o_en, o_done, o_busy);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL back_idle: done=%b busy=%b ready=%b required 0 0 0", o_done, o_busy, o_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_we !== 1'b0) begin
            n_err++;
            $display("FAIL stays_idle: busy=%b we=%b required 0 0", o_busy, o_we);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 16'h0000; fc_all_end = 1'b0;
        set_cfg(1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({a_ready, a_we, a_en, a_busy, a_done, a_val, a_addr} !== 37'd0 ||
            {b_ready, b_we, b_en, b_busy, b_done, b_val, b_addr} !== 37'd0) begin
            n_err++;
            $display("FAIL reset_values: a=%b%b%b%b%b %h %h b=%b%b%b%b%b %h %h required all 0",
                     a_ready, a_we, a_en, a_busy, a_done, a_val, a_addr,
                     b_ready, b_we, b_en, b_busy, b_done, b_val, b_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_default();
        set_cfg(1'b0);
        do_frame(0, 14, 1'b0);
        test_run_end(20);
    endtask

    task automatic test_stall();
        set_cfg(1'b1);
        do_frame(1, 12, 1'b0);
        test_run_end(4);
    endtask

    task automatic test_ignore();
        set_cfg(1'b0);
        do_frame(2, 14, 1'b1);
        test_run_end(6);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            set_cfg(1'(r % 2));
            do_frame(2, cfg_ch * cfg_h * cfg_w, 1'b0);
            test_run_end(1 + r);
        end
    endtask

    task automatic test_mid_reset();
        for (int s = 0; s < 2; s++) begin
            set_cfg(1'(s));
            do_frame(0, 5, 1'b0);
            #2 reset_n = 1'b0;
            #1;
            n_cmp++;
            if ({o_ready, o_we, o_en, o_busy, o_done, o_val, o_addr} !== 37'd0) begin
                n_err++;
                $display("FAIL async_reset: ready=%b we=%b en=%b busy=%b done=%b val=%h addr=%h required all 0",
                         o_ready, o_we, o_en, o_busy, o_done, o_val, o_addr);
            end
            @(negedge clk);
            reset_n = 1'b1;
            do_frame(0, cfg_ch * cfg_h * cfg_w, 1'b0);
            test_run_end(2);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_stall();
        test_ignore();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
